// File: rtl/dot_product_sequencer.sv
// Streams signed operand pairs through a multi-cycle multiplier and accumulates
// the products into a dot-product result presented on a valid/ready output.
module dot_product_sequencer #(
   parameter  int WIDTH       = 10,
   parameter  int ACC_GUARD   = 8,
   parameter  int COUNT_WIDTH = 8,
   localparam int ACC_W       = 2*WIDTH + 2 + ACC_GUARD
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic signed [WIDTH:0]         in_a,
   input  logic signed [WIDTH:0]         in_b,
   input  logic                          in_last,
   input  logic                          in_valid,
   output logic                          in_ready,
   output logic signed [WIDTH:0]         mul_a,
   output logic signed [WIDTH:0]         mul_b,
   output logic                          mul_start,
   input  logic signed [2*WIDTH+1:0]     mul_c,
   input  logic                          mul_valid,
   output logic signed [ACC_W-1:0]       out_sum,
   output logic        [COUNT_WIDTH-1:0] out_count,
   output logic                          out_overflow,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic                          busy
);

   typedef enum logic [2:0] {
      S_IDLE, S_ISSUE, S_WAIT, S_CAPTURE, S_DONE
   } state_t;

   state_t state, state_next;

   logic                          last_q;
   logic signed [ACC_W-1:0]       acc;
   logic        [COUNT_WIDTH-1:0] count;
   logic                          overflow;
   logic signed [ACC_W-1:0]       prod_ext;
   logic signed [ACC_W-1:0]       acc_next;
   logic                          ovf_next;

   function automatic logic signed [ACC_W-1:0] sext_prod(input logic signed [2*WIDTH+1:0] p);
      return ACC_W'(p);
   endfunction

   // Two's-complement overflow: same-sign addends producing a different-sign sum.
   function automatic logic add_ovf(input logic signed [ACC_W-1:0] x,
                                    input logic signed [ACC_W-1:0] y,
                                    input logic signed [ACC_W-1:0] s);
      return (x[ACC_W-1] == y[ACC_W-1]) && (s[ACC_W-1] != x[ACC_W-1]);
   endfunction

   function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] c);
      return (&c) ? c : c + COUNT_WIDTH'(1);
   endfunction

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:    if (in_valid)  state_next = S_ISSUE;
         S_ISSUE:                  state_next = S_WAIT;
         S_WAIT:    if (mul_valid) state_next = S_CAPTURE;
         S_CAPTURE:                state_next = last_q ? S_DONE : S_IDLE;
         S_DONE:    if (out_ready) state_next = S_IDLE;
         default:                  state_next = S_IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state == S_IDLE);
      mul_start = (state == S_ISSUE);
      out_valid = (state == S_DONE);
      busy      = (state != S_IDLE);
   end

   always_comb begin
      prod_ext = sext_prod(mul_c);
      acc_next = acc + prod_ext;
      ovf_next = overflow | add_ovf(acc, prod_ext, acc_next);
   end

   // The product is only trusted in CAPTURE, one cycle after mul_valid.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         mul_a        <= '0;
         mul_b        <= '0;
         last_q       <= 1'b0;
         acc          <= '0;
         count        <= '0;
         overflow     <= 1'b0;
         out_sum      <= '0;
         out_count    <= '0;
         out_overflow <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  mul_a  <= in_a;
                  mul_b  <= in_b;
                  last_q <= in_last;
               end
            end
            S_CAPTURE: begin
               acc      <= acc_next;
               count    <= sat_inc(count);
               overflow <= ovf_next;
               if (last_q) begin
                  out_sum      <= acc_next;
                  out_count    <= sat_inc(count);
                  out_overflow <= ovf_next;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  acc      <= '0;
                  count    <= '0;
                  overflow <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_dot_product_sequencer.sv
// Directed bench: two sequencer instances (default guard bits and zero guard
// bits) share stimulus, each driven by a behavioural two-cycle multiplier.
module tb_dot_product_sequencer;

   localparam int W = 10;

   logic clock = 1'b0;
   logic reset;
   logic signed [W:0] in_a, in_b;
   logic in_last, in_valid, out_ready, spur_valid;

   logic in_ready1, mul_start1, mul_valid1, out_overflow1, out_valid1, busy1;
   logic signed [W:0] mul_a1, mul_b1;
   logic signed [2*W+1:0] mul_c1;
   logic signed [29:0] out_sum1;
   logic [7:0] out_count1;
   logic m1_valid;

   logic in_ready2, mul_start2, mul_valid2, out_overflow2, out_valid2, busy2;
   logic signed [W:0] mul_a2, mul_b2;
   logic signed [2*W+1:0] mul_c2;
   logic signed [21:0] out_sum2;
   logic [7:0] out_count2;
   logic m2_valid;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clock = ~clock;

   dot_product_sequencer #(.WIDTH(W), .ACC_GUARD(8), .COUNT_WIDTH(8)) dut1 (
      .clock(clock), .reset(reset), .in_a(in_a), .in_b(in_b), .in_last(in_last),
      .in_valid(in_valid), .in_ready(in_ready1), .mul_a(mul_a1), .mul_b(mul_b1),
      .mul_start(mul_start1), .mul_c(mul_c1), .mul_valid(mul_valid1),
      .out_sum(out_sum1), .out_count(out_count1), .out_overflow(out_overflow1),
      .out_valid(out_valid1), .out_ready(out_ready), .busy(busy1));

   dot_product_sequencer #(.WIDTH(W), .ACC_GUARD(0), .COUNT_WIDTH(8)) dut2 (
      .clock(clock), .reset(reset), .in_a(in_a), .in_b(in_b), .in_last(in_last),
      .in_valid(in_valid), .in_ready(in_ready2), .mul_a(mul_a2), .mul_b(mul_b2),
      .mul_start(mul_start2), .mul_c(mul_c2), .mul_valid(mul_valid2),
      .out_sum(out_sum2), .out_count(out_count2), .out_overflow(out_overflow2),
      .out_valid(out_valid2), .out_ready(out_ready), .busy(busy2));

   // Multiplier model: valid the cycle after start, c written at the end of
   // that cycle; c holds junk during the valid cycle itself.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         m1_valid <= 1'b0; mul_c1 <= '0;
      end else if (mul_start1) begin
         m1_valid <= 1'b1; mul_c1 <= 22'sh15A5A5;
      end else if (m1_valid) begin
         m1_valid <= 1'b0; mul_c1 <= 22'(mul_a1) * 22'(mul_b1);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         m2_valid <= 1'b0; mul_c2 <= '0;
      end else if (mul_start2) begin
         m2_valid <= 1'b1; mul_c2 <= 22'sh15A5A5;
      end else if (m2_valid) begin
         m2_valid <= 1'b0; mul_c2 <= 22'(mul_a2) * 22'(mul_b2);
      end
   end

   assign mul_valid1 = m1_valid | spur_valid;
   assign mul_valid2 = m2_valid | spur_valid;

   typedef struct packed {
      int                n;
      logic [2:0][W:0]   a;
      logic [2:0][W:0]   b;
      longint            sum;
      int                cnt;
   } vec_t;

   vec_t tbl [5];

   task automatic check(input string name, input longint act, input longint exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic set_vec(input int i, input int n,
                          input int a0, input int b0, input int a1, input int b1,
                          input int a2, input int b2, input longint sum, input int cnt);
      tbl[i].n = n;
      tbl[i].a[0] = 11'(a0); tbl[i].b[0] = 11'(b0);
      tbl[i].a[1] = 11'(a1); tbl[i].b[1] = 11'(b1);
      tbl[i].a[2] = 11'(a2); tbl[i].b[2] = 11'(b2);
      tbl[i].sum = sum;
      tbl[i].cnt = cnt;
   endtask

   // Called at a negedge; returns at the negedge after the accepting posedge.
   task automatic send_pair(input logic signed [W:0] a, input logic signed [W:0] b,
                            input logic last);
      int w;
      in_a = a; in_b = b; in_last = last; in_valid = 1'b1;
      w = 0;
      while (!in_ready1 && w < 50) begin
         @(negedge clock);
         w++;
      end
      if (!in_ready1) check("accept_timeout", 0, 1);
      @(negedge clock);
      in_valid = 1'b0;
   endtask

   task automatic wait_result(output int lat);
      lat = 1;
      while (!out_valid1 && lat < 60) begin
         @(negedge clock);
         lat++;
      end
   endtask

   initial begin
      int lat;
      int pa [3];
      int pb [3];
      pa = '{1, 3, 5};
      pb = '{2, 4, 6};

      set_vec(0, 3,     3,     4,   -5,  6,   7,  -2,     -32, 3);
      set_vec(1, 1, -1024, -1024,    0,  0,   0,   0, 1048576, 1);
      set_vec(2, 2,  1023,  1023,   -1,  1,   0,   0, 1046528, 2);
      set_vec(3, 1,     0,     0,    0,  0,   0,   0,       0, 1);
      set_vec(4, 3,    -7,     3,   -2, -9, 100, -10,   -1003, 3);

      reset = 1'b1; in_a = '0; in_b = '0; in_last = 1'b0; in_valid = 1'b0;
      out_ready = 1'b1; spur_valid = 1'b0;
      repeat (2) @(negedge clock);
      check("rst_in_ready",  longint'(in_ready1), 1);
      check("rst_busy",      longint'(busy1), 0);
      check("rst_out_valid", longint'(out_valid1), 0);
      check("rst_out_sum",   longint'(out_sum1), 0);
      check("rst_mul_start", longint'(mul_start1), 0);
      reset = 1'b0;
      @(negedge clock);

      for (int i = 0; i < 5; i++) begin
         for (int j = 0; j < tbl[i].n; j++)
            send_pair(tbl[i].a[j], tbl[i].b[j], j == tbl[i].n - 1);
         wait_result(lat);
         check($sformatf("vec%0d_latency", i), lat, 4);
         check($sformatf("vec%0d_valid", i), longint'(out_valid1), 1);
         check($sformatf("vec%0d_sum", i), longint'(out_sum1), tbl[i].sum);
         check($sformatf("vec%0d_count", i), longint'(out_count1), tbl[i].cnt);
         check($sformatf("vec%0d_ovf", i), longint'(out_overflow1), 0);
         @(negedge clock);
         check($sformatf("vec%0d_valid_drop", i), longint'(out_valid1), 0);
      end

      // Stray mul_valid while idle must be ignored.
      spur_valid = 1'b1;
      @(negedge clock);
      spur_valid = 1'b0;
      check("spur_idle_busy", longint'(busy1), 0);

      // Back-to-back pairs with in_valid held high.
      for (int c = 0; c <= 12; c++) begin
         if (c < 12) begin
            in_a = 11'(pa[c/4]); in_b = 11'(pb[c/4]);
            in_last = (c/4 == 2); in_valid = 1'b1;
            check($sformatf("thr_in_ready_c%0d", c), longint'(in_ready1), longint'(c % 4 == 0));
            check($sformatf("thr_mul_start_c%0d", c), longint'(mul_start1), longint'(c % 4 == 1));
            if (c % 4 == 2) begin
               check($sformatf("thr_mul_a_c%0d", c), longint'(mul_a1), pa[c/4]);
               check($sformatf("thr_mul_b_c%0d", c), longint'(mul_b1), pb[c/4]);
            end
         end else begin
            in_valid = 1'b0;
            check("thr_out_valid", longint'(out_valid1), 1);
            check("thr_sum", longint'(out_sum1), 44);
            check("thr_count", longint'(out_count1), 3);
         end
         @(negedge clock);
      end
      check("thr_valid_drop", longint'(out_valid1), 0);

      // Backpressure with a pending input pair and stray mul_valid in DONE.
      out_ready = 1'b0;
      send_pair(2, 5, 1'b0);
      send_pair(3, 3, 1'b1);
      wait_result(lat);
      check("bp_valid", longint'(out_valid1), 1);
      in_a = 4; in_b = 4; in_last = 1'b1; in_valid = 1'b1;
      spur_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clock);
         if (k == 1) spur_valid = 1'b0;
         check($sformatf("bp_hold_valid_%0d", k), longint'(out_valid1), 1);
         check($sformatf("bp_hold_sum_%0d", k), longint'(out_sum1), 19);
         check($sformatf("bp_hold_in_ready_%0d", k), longint'(in_ready1), 0);
      end
      out_ready = 1'b1;
      @(negedge clock);
      check("bp_release_valid", longint'(out_valid1), 0);
      check("bp_release_in_ready", longint'(in_ready1), 1);
      check("bp_release_sum_held", longint'(out_sum1), 19);
      @(negedge clock);
      in_valid = 1'b0;
      wait_result(lat);
      check("bp_next_sum", longint'(out_sum1), 16);
      check("bp_next_count", longint'(out_count1), 1);
      @(negedge clock);

      // Zero guard bits: accumulator wraps and flags overflow.
      send_pair(-1024, -1024, 1'b0);
      send_pair(-1024, -1024, 1'b1);
      wait_result(lat);
      check("ovf_wide_sum", longint'(out_sum1), 2097152);
      check("ovf_wide_flag", longint'(out_overflow1), 0);
      check("ovf_narrow_valid", longint'(out_valid2), 1);
      check("ovf_narrow_sum", longint'(out_sum2), -2097152);
      check("ovf_narrow_count", longint'(out_count2), 2);
      check("ovf_narrow_flag", longint'(out_overflow2), 1);
      @(negedge clock);
      send_pair(1, 1, 1'b1);
      wait_result(lat);
      check("ovf_next_sum", longint'(out_sum2), 1);
      check("ovf_next_flag", longint'(out_overflow2), 0);
      @(negedge clock);

      // Reset in WAIT aborts the packet.
      send_pair(9, 9, 1'b0);
      @(negedge clock);
      check("rw_in_wait", longint'(busy1), 1);
      #1 reset = 1'b1;
      #1;
      check("rw_out_sum", longint'(out_sum1), 0);
      check("rw_out_count", longint'(out_count1), 0);
      check("rw_out_ovf", longint'(out_overflow1), 0);
      check("rw_out_valid", longint'(out_valid1), 0);
      check("rw_busy", longint'(busy1), 0);
      check("rw_mul_a", longint'(mul_a1), 0);
      check("rw_in_ready", longint'(in_ready1), 1);
      check("rw_busy2", longint'(busy2), 0);
      check("rw_in_ready2", longint'(in_ready2), 1);
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      send_pair(2, 3, 1'b1);
      wait_result(lat);
      check("rw_next_sum", longint'(out_sum1), 6);
      check("rw_next_count", longint'(out_count1), 1);
      check("rw_next_latency", lat, 4);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/dot_product_sequencer.md
Name: dot_product_sequencer

Overview:
- Upstream/downstream wrapper around the multi-cycle `multiplier`. It accepts a stream of signed operand pairs with a last flag and issues each pair to the multiplier.
- It accumulates the returned products and presents the dot-product sum, term count and overflow flag on a valid/ready output.
- It sits between the operand-fetch logic and the result consumer in the arithmetic datapath.

Parameters:
WIDTH, 10, operand MSB index; operands are WIDTH+1 bits signed, matches multiplier WIDTH
ACC_GUARD, 8, guard bits; accumulator width ACC_W = 2*WIDTH+2+ACC_GUARD
COUNT_WIDTH, 8, width of term counter

Ports:
clock  in  1  clock
reset  in  1  asynchronous, active-high reset
in_a  in  WIDTH+1  signed operand a
in_b  in  WIDTH+1  signed operand b
in_last  in  1  pair is final term of the current dot product
in_valid  in  1  input pair valid
in_ready  out  1  block accepts a pair this cycle
mul_a  out  WIDTH+1  to multiplier a (registered)
mul_b  out  WIDTH+1  to multiplier b (registered)
mul_start  out  1  to multiplier start
mul_c  in  2*WIDTH+2  signed product from multiplier
mul_valid  in  1  multiplier valid (high for its calculate cycle)
out_sum  out  ACC_W  signed accumulated sum
out_count  out  COUNT_WIDTH  number of terms in out_sum
out_overflow  out  1  sticky: signed accumulation overflowed
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset is `reset`: asynchronous, active-high; clock is `clock`, rising edge. On reset every register clears:
  - state=IDLE
  - mul_a=mul_b=0, mul_start=0
  - accumulator=0, count=0, overflow=0
  - out_sum=0, out_count=0, out_overflow=0, out_valid=0
  - the latched last flag clears.
- The FSM has five states:
  - IDLE: in_ready=1. On in_valid, latch in_a->mul_a, in_b->mul_b, in_last, then go to ISSUE.
  - ISSUE: mul_start=1 for exactly this cycle; mul_a/mul_b held stable. Go to WAIT.
  - WAIT: stay until mul_valid=1, then go to CAPTURE. The product is not sampled in WAIT.
  - CAPTURE: mul_c is valid now (multiplier writes c at the end of its valid cycle). Apply the accumulation and counter rules below. If the latched last=1, load out_sum/out_count/out_overflow from the post-add values, then go to DONE. Otherwise go to IDLE.
  - DONE: out_valid=1, in_ready=0. On out_ready, go to IDLE and clear accumulator, count and overflow. out_* registers hold their values; out_valid drops.
- Accumulation (CAPTURE): acc <= acc + sign-extend(mul_c) to ACC_W, two's-complement wrap. overflow |= (operand signs equal and result sign differs).
- Term counter (CAPTURE): count <= count+1, saturating at 2^COUNT_WIDTH-1.
- in_ready is combinationally (state==IDLE). in_ready is not asserted in DONE, so there is no accept/result overlap.
- mul_start is never asserted outside ISSUE. mul_start is never re-asserted before CAPTURE completes, so the multiplier is guaranteed back in read_input at the next ISSUE.
- Throughput: one pair per 4 cycles with in_valid held. Accept at cycle 0, then:
  - cycle 1: mul_start
  - cycle 2: mul_valid
  - cycle 3: CAPTURE
  - cycle 4: in_ready=1 again
- Result latency: out_valid rises in the cycle after CAPTURE of the last term, i.e. 4 cycles after the last accept.
- Boundaries:
  - A mul_valid seen in IDLE/ISSUE/DONE is ignored.
  - A single-term packet (in_last on the first pair) is legal.
  - out_valid is held indefinitely while out_ready=0.
  - Reset in any state aborts the packet with no partial output; the next packet starts from zero.

Test Plan:
- Packet (3,4),(-5,6),(7,-2,last), out_ready=1 -> out_sum=-32, out_count=3, out_overflow=0; out_valid high 1 cycle.
- Single pair (-1024,-1024,last) -> out_sum=1048576, out_count=1; out_valid exactly 4 cycles after accept.
- in_valid held high across 3 pairs -> in_ready pulses every 4 cycles; mul_start exactly 1 cycle after each accept; mul_a/mul_b stable through WAIT.
- Backpressure: out_ready=0 for 5 cycles after result -> out_valid and out_sum held, in_ready=0; release -> out_valid drops next cycle, next packet sums from 0.
- ACC_GUARD=0 (ACC_W=22), two pairs (-1024,-1024) -> out_sum=-2097152 (wrapped), out_overflow=1; next packet overflow=0.
- reset asserted in WAIT of a 2-term packet -> all outputs 0 immediately; following packet (2,3,last) -> out_sum=6, out_count=1.
